// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end. Owns the fetch PC, issues word requests on the
// instruction bus, tags every granted request with its PC, and buffers the
// returned words in a 2-entry in-order queue whose head feeds IF/ID.
// A redirect squashes the queue immediately; responses still in flight for
// the old stream are counted and silently dropped when they arrive.

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [31:0] pc_q, pc_d;

  // instruction queue
  logic [31:0] q_pc_q   [2];
  logic [31:0] q_pc_d   [2];
  logic [31:0] q_inst_q [2];
  logic [31:0] q_inst_d [2];
  logic        q_rd_q, q_rd_d;
  logic        q_wr_q, q_wr_d;
  logic [1:0]  cnt_q, cnt_d;

  // in-flight request tracking; the tag FIFO depth equals out_q
  logic [31:0] tag_pc_q [2];
  logic [31:0] tag_pc_d [2];
  logic        tag_rd_q, tag_rd_d;
  logic        tag_wr_q, tag_wr_d;
  logic [1:0]  out_q, out_d;
  logic [1:0]  disc_q, disc_d;

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic [2:0]  credit_used;
  logic        req;
  logic        gnt_acc;
  logic        rsp_acc;
  logic        rsp_drop;
  logic        push;
  logic        pop;
  logic [31:0] redirect_pc_aligned;

  // Low address bits of a redirect target are meaningless for word fetch.
  assign redirect_pc_aligned = redirect_pc_i & ~32'h0000_0003;

  // Credit counts only registered occupancy, so a pop in this cycle never
  // opens a slot for a request in the same cycle.
  assign credit_used = {1'b0, cnt_q} + {1'b0, out_q};

  // Request is combinational on registered credit; suppressed during reset
  // and during a redirect so the old PC is never requested in that cycle.
  always_comb begin
    req = 1'b0;
    if (!rst && !redirect_i && (credit_used < 3'd2)) begin
      req = 1'b1;
    end
  end

  assign gnt_acc = req && ibus_gnt_i;

  // A response with nothing outstanding is a bus protocol error; ignoring it
  // keeps the counters from wrapping.
  assign rsp_acc  = ibus_rvalid_i && (out_q != 2'd0);
  assign rsp_drop = rsp_acc && (disc_q != 2'd0);

  assign inst_valid_o = (cnt_q != 2'd0);

  // Redirect owns the cycle: nothing enters or leaves the queue.
  assign push = rsp_acc && !rsp_drop && !redirect_i;
  assign pop  = inst_valid_o && !stall_i && !redirect_i;

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ibus_req_o  = req;
  assign ibus_addr_o = pc_q;
  assign inst_o      = q_inst_q[q_rd_q];
  assign inst_pc_o   = q_pc_q[q_rd_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------

  // Fetch PC: redirect target wins, otherwise advance by one word per grant.
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_aligned;
    end else if (gnt_acc) begin
      pc_d = pc_q + 32'd4;
    end
  end

  // Outstanding count and tag FIFO move with every grant and response.
  always_comb begin
    out_d    = out_q + {1'b0, gnt_acc} - {1'b0, rsp_acc};
    tag_pc_d = tag_pc_q;
    tag_wr_d = tag_wr_q;
    tag_rd_d = tag_rd_q;
    if (gnt_acc) begin
      tag_pc_d[tag_wr_q] = pc_q;
      tag_wr_d           = ~tag_wr_q;
    end
    if (rsp_acc) begin
      tag_rd_d = ~tag_rd_q;
    end
  end

  // Discard count: on redirect every request still in flight after this
  // cycle belongs to the squashed stream; otherwise it drains one per drop.
  always_comb begin
    disc_d = disc_q;
    if (redirect_i) begin
      disc_d = out_q + {1'b0, gnt_acc} - {1'b0, rsp_acc};
    end else if (rsp_drop) begin
      disc_d = disc_q - 2'd1;
    end
  end

  // Instruction queue: push at the write pointer with the request's tag PC,
  // pop at the read pointer; redirect empties it and realigns the pointers.
  always_comb begin
    q_pc_d   = q_pc_q;
    q_inst_d = q_inst_q;
    q_wr_d   = q_wr_q;
    q_rd_d   = q_rd_q;
    cnt_d    = cnt_q;
    if (redirect_i) begin
      q_wr_d = 1'b0;
      q_rd_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (push) begin
        q_pc_d[q_wr_q]   = tag_pc_q[tag_rd_q];
        q_inst_d[q_wr_q] = ibus_rdata_i;
        q_wr_d           = ~q_wr_q;
      end
      if (pop) begin
        q_rd_d = ~q_rd_q;
      end
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------

  // Fetch PC register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // In-flight tracking registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= 2'd0;
      disc_q   <= 2'd0;
      tag_rd_q <= 1'b0;
      tag_wr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        tag_pc_q[i] <= 32'd0;
      end
    end else begin
      out_q    <= out_d;
      disc_q   <= disc_d;
      tag_rd_q <= tag_rd_d;
      tag_wr_q <= tag_wr_d;
      tag_pc_q <= tag_pc_d;
    end
  end

  // Instruction queue registers; contents reset so the head outputs are 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      q_rd_q <= 1'b0;
      q_wr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc_q[i]   <= 32'd0;
        q_inst_q[i] <= 32'd0;
      end
    end else begin
      cnt_q    <= cnt_d;
      q_rd_q   <= q_rd_d;
      q_wr_q   <= q_wr_d;
      q_pc_q   <= q_pc_d;
      q_inst_q <= q_inst_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed bench with a bus model and an expected-instruction
// scoreboard. Grants push {pc, word} to the scoreboard; each instruction the
// DUT hands downstream is popped and compared. A redirect empties the
// scoreboard, so any old-stream instruction that leaks out is caught.

module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  if_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .inst_pc_o     (inst_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          errors;
  int          cyc;
  int          first_gnt_cyc;
  int          gnts;
  bit          gnt_en;
  bit          rv_en;
  bit          seen_gnt;
  bit          seen_vld;
  logic [31:0] exp_addr;
  logic [31:0] bus_q[$];
  logic [63:0] sb[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle, entered and left just after a falling edge.
  task automatic tick();
    logic        g;
    logic        rv;
    logic [63:0] e;
    #1;
    if (redirect_i) begin
      chk("req_low_on_redirect", {31'd0, ibus_req_o}, 32'd0);
      sb.delete();
      exp_addr = {redirect_pc_i[31:2], 2'b00};
    end
    g  = ibus_req_o && gnt_en;
    rv = rv_en && (bus_q.size() != 0);
    ibus_gnt_i    = g;
    ibus_rvalid_i = rv;
    ibus_rdata_i  = rv ? mem(bus_q[0]) : 32'd0;
    if (rv) void'(bus_q.pop_front());
    #1;
    if (g) begin
      chk("gnt_addr", ibus_addr_o, exp_addr);
      bus_q.push_back(ibus_addr_o);
      sb.push_back({exp_addr, mem(exp_addr)});
      exp_addr = exp_addr + 32'd4;
      gnts++;
      if (!seen_gnt) begin
        seen_gnt      = 1'b1;
        first_gnt_cyc = cyc;
      end
    end
    if (inst_valid_o && !seen_vld && seen_gnt) begin
      seen_vld = 1'b1;
      chk("first_valid_cycle", 32'(cyc), 32'(first_gnt_cyc + 2));
    end
    if (inst_valid_o && !stall_i && !redirect_i) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_inst: observed pc %h expected none", inst_pc_o);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("inst_pc", inst_pc_o, e[63:32]);
        chk("inst_word", inst_o, e[31:0]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    stall_i = 1'b0;
    gnt_en  = 1'b0;
    rv_en   = 1'b1;
    repeat (5) tick();
    chk("drain_sb_empty", 32'(sb.size()), 32'd0);
    chk("drain_valid_low", {31'd0, inst_valid_o}, 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_i    = 1'b1;
    redirect_pc_i = target;
    tick();
    redirect_i    = 1'b0;
  endtask

  // Wait (bounded) for the first valid head and check its PC.
  task automatic expect_first_pc(input string tag, input logic [31:0] pc);
    int n;
    n = 0;
    while (!inst_valid_o && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, {31'd0, inst_valid_o}, 32'd1);
    chk({tag, "_pc"}, inst_pc_o, pc);
  endtask

  initial begin
    logic [31:0] hold_pc;
    logic [31:0] hold_inst;
    bit          captured;
    int          gnts_before;
    int          n;

    checks = 0; errors = 0; cyc = 0; gnts = 0; first_gnt_cyc = 0;
    seen_gnt = 1'b0; seen_vld = 1'b0;
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'd0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'd0;
    gnt_en = 1'b0; rv_en = 1'b0;
    exp_addr = RESET_PC;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_req", {31'd0, ibus_req_o}, 32'd0);
    chk("rst_addr", ibus_addr_o, RESET_PC);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_inst_pc", inst_pc_o, 32'd0);

    // streaming from reset, gnt always, rvalid one cycle later
    rst = 1'b0;
    #1;
    chk("first_req", {31'd0, ibus_req_o}, 32'd1);
    chk("first_addr", ibus_addr_o, RESET_PC);
    #1;
    @(negedge clk);
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    repeat (12) tick();

    // stall for 5 cycles: head frozen, no more than 2 further grants
    stall_i     = 1'b1;
    captured    = 1'b0;
    gnts_before = gnts;
    hold_pc     = 32'd0;
    hold_inst   = 32'd0;
    repeat (5) begin
      if (inst_valid_o) begin
        if (!captured) begin
          hold_pc   = inst_pc_o;
          hold_inst = inst_o;
          captured  = 1'b1;
        end else begin
          chk("stall_head_pc", inst_pc_o, hold_pc);
          chk("stall_head_inst", inst_o, hold_inst);
        end
      end
      tick();
    end
    chk("stall_grants_le2", 32'(gnts - gnts_before <= 2), 32'd1);
    chk("stall_req_dropped", {31'd0, ibus_req_o}, 32'd0);
    chk("stall_head_valid", {31'd0, inst_valid_o}, 32'd1);
    stall_i = 1'b0;
    repeat (8) tick();

    // grant withheld: address holds, pc advances only on grant
    gnt_en = 1'b0;
    repeat (2) tick();
    hold_pc = ibus_addr_o;
    repeat (3) begin
      #1;
      chk("nognt_req", {31'd0, ibus_req_o}, 32'd1);
      chk("nognt_addr", ibus_addr_o, hold_pc);
      chk("nognt_addr_model", ibus_addr_o, exp_addr);
      @(negedge clk);
      tick();
    end
    gnt_en = 1'b1;
    repeat (6) tick();

    // redirect to 0x1003 with 2 outstanding
    drain();
    gnt_en = 1'b1;
    rv_en  = 1'b0;
    repeat (2) tick();
    redirect_to(32'h0000_1003);
    chk("rdA_addr", ibus_addr_o, 32'h0000_1000);
    chk("rdA_valid_low", {31'd0, inst_valid_o}, 32'd0);
    rv_en = 1'b1;
    expect_first_pc("rdA_first", 32'h0000_1000);
    repeat (6) tick();

    // redirect in the same cycle as an old response
    drain();
    gnt_en = 1'b1;
    rv_en  = 1'b0;
    repeat (2) tick();
    rv_en = 1'b1;
    redirect_to(32'h0000_2000);
    chk("rdB_valid_low", {31'd0, inst_valid_o}, 32'd0);
    expect_first_pc("rdB_first", 32'h0000_2000);
    repeat (6) tick();

    // minimum redirect-to-valid latency
    drain();
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    redirect_to(32'h0000_3000);
    chk("rdC_r1_valid", {31'd0, inst_valid_o}, 32'd0);
    tick();
    chk("rdC_r2_valid", {31'd0, inst_valid_o}, 32'd0);
    tick();
    chk("rdC_r3_valid", {31'd0, inst_valid_o}, 32'd1);
    chk("rdC_r3_pc", inst_pc_o, 32'h0000_3000);
    repeat (6) tick();

    // redirect with a full queue, then wrap past the top of memory
    stall_i = 1'b1;
    repeat (4) tick();
    chk("rdD_pre_valid", {31'd0, inst_valid_o}, 32'd1);
    redirect_to(32'hFFFF_FFFA);
    stall_i = 1'b0;
    chk("rdD_valid_low", {31'd0, inst_valid_o}, 32'd0);
    chk("rdD_addr", ibus_addr_o, 32'hFFFF_FFF8);
    n = 0;
    while (exp_addr != 32'd0 && n < 10) begin
      tick();
      n++;
    end
    chk("wrap_addr", ibus_addr_o, 32'h0000_0000);
    repeat (8) tick();

    // asynchronous reset in the middle of streaming
    #3;
    rst = 1'b1;
    ibus_gnt_i = 1'b0;
    ibus_rvalid_i = 1'b0;
    #1;
    chk("arst_req", {31'd0, ibus_req_o}, 32'd0);
    chk("arst_addr", ibus_addr_o, RESET_PC);
    chk("arst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("arst_inst_pc", inst_pc_o, 32'd0);
    bus_q.delete();
    sb.delete();
    exp_addr = RESET_PC;
    seen_gnt = 1'b0;
    seen_vld = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    gnt_en = 1'b1;
    rv_en  = 1'b1;
    repeat (8) tick();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
